// File: rtl/chunked_subtractor_pkg.sv
// Shared types and helpers for the chunked subtractor.
// FSM state encoding and the chunk-index width calculation.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/chunked_subtractor_chunk.sv
// Combinational CHUNK-bit ripple of full-subtractor cells.
// bmsb is the borrow entering the top cell, used for signed overflow.
module subtractor_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout,
  output logic             bmsb
);

  logic w_brw;

  always_comb begin
    w_brw = bin;
    d     = '0;
    bmsb  = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) bmsb = w_brw;
      d[i]  = x[i] ^ y[i] ^ w_brw;
      w_brw = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_brw);
    end
    bout = w_brw;
  end

endmodule

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, CHUNK bits per clock, LSB first.
// Optional zero/ovf flag outputs are enabled by defining SUB_FLAGS_EN.
module chunked_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_subtractor: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_borrow;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef SUB_FLAGS_EN
  logic             r_zero;
  logic             r_ovf;
`endif

  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_d;
  logic             w_bout;
  logic             w_bmsb;
  logic [WIDTH-1:0] w_diff_upd;

  // Constant-index mux keeps every slice in range for any NCHUNK.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IW'(k)) begin
        w_x = r_a[k*CHUNK +: CHUNK];
        w_y = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    w_diff_upd = r_diff;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (r_idx == IW'(k)) w_diff_upd[k*CHUNK +: CHUNK] = w_d;
    end
  end

  subtractor_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (w_x),
    .y    (w_y),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout),
    .bmsb (w_bmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SUB_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= b_in;
            r_idx    <= '0;
            r_diff   <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_diff_upd;
          r_borrow <= w_bout;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_bout  <= w_bout;
            r_state <= DONE;
`ifdef SUB_FLAGS_EN
            r_zero  <= (w_diff_upd == '0);
            r_ovf   <= w_bmsb ^ w_bout;
`endif
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifndef SUB_FLAGS_EN
  logic w_unused;
  assign w_unused = w_bmsb;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign b_out     = r_bout;
`ifdef SUB_FLAGS_EN
  assign zero      = r_zero;
  assign ovf       = r_ovf;
`endif

endmodule
